watchdog_kick_controller: RTL and testbench
===========================================

# watchdog_kick_controller

Supervisor-side companion to the system watchdog timer. It programs and arms the watchdog, optionally locks its configuration, collects per-task heartbeat pulses, and emits a kick only when every required task has checked in within a service period. It also performs the key-based unlock-and-disable sequence on request. It sits between the software-task heartbeat sources and the watchdog's configuration and kick inputs.

## Interface
- NUM_TASKS, 4, number of heartbeat sources (1..16)
- COUNTER_WIDTH, 32, width of timeout and period values
- KICK_PULSE_CYCLES, 4, kick high time in cycles (1..15)
- HANDSHAKE_LIMIT, 8, max cycles to wait for lock/unlock acknowledge

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; latch cfg_timeout/cfg_lock and begin arming (IDLE only)
- stop_req  in  1  pulse; unlock and disable watchdog (RUN only)
- cfg_timeout  in  COUNTER_WIDTH  timeout to program
- cfg_lock  in  1  lock watchdog config after enable
- kick_period  in  COUNTER_WIDTH  service period length in cycles
- task_mask  in  NUM_TASKS  1 = task required for a kick
- heartbeat  in  NUM_TASKS  per-task single-cycle check-in pulses
- wdt_config_locked  in  1  watchdog lock status
- wdt_timeout  in  1  watchdog timeout pulse
- watchdog_enable  out  1  to watchdog enable
- timeout_value  out  COUNTER_WIDTH  to watchdog timeout_value
- lock_config  out  1  to watchdog lock request
- unlock_key  out  32  to watchdog unlock key
- kick_watchdog  out  1  to watchdog kick (edge-detected by the watchdog)
- missing_tasks  out  NUM_TASKS  required tasks absent in last failed period
- kick_count  out  16  kicks issued, saturating
- starve_fault  out  1  sticky: at least one period withheld its kick
- handshake_fault  out  1  sticky: lock/unlock acknowledge timed out
- timeout_seen  out  1  sticky: wdt_timeout observed
- active  out  1  state != IDLE

## Operation
- FSM states: IDLE, CONFIG, LOCK, RUN, UNLOCK.
- IDLE: enable=0, timeout_value=0, lock_config=0, unlock_key=0, kick=0. On start, latch cfg_timeout→timeout_value and cfg_lock, then go to CONFIG.
- CONFIG: watchdog_enable=1 for 2 cycles. Then go to LOCK if the latched lock flag is set, else RUN.
- LOCK: lock_config=1 until wdt_config_locked=1 is sampled, then RUN. If not sampled within HANDSHAKE_LIMIT cycles: set handshake_fault, drop lock_config, go to RUN.
- RUN: watchdog_enable=1.
  - Period counter counts 0..P-1, where P = max(kick_period, KICK_PULSE_CYCLES+1).
  - seen register: seen <= seen | heartbeat every cycle.
  - At the last cycle of the period, evaluate eval = seen | heartbeat, so same-cycle heartbeats count.
    - If (eval & task_mask) == task_mask: kick_watchdog=1 for KICK_PULSE_CYCLES cycles, then 0, and kick_count increments, saturating at 16'hFFFF.
    - Otherwise: no kick, missing_tasks <= task_mask & ~eval, starve_fault set.
  - seen clears at period rollover.
  - A task_mask of 0 always passes.
- wdt_timeout in RUN: set timeout_seen, clear seen, restart the period counter at 0, and abort any kick pulse in progress.
- stop_req in RUN (or LOCK): go to UNLOCK.
- UNLOCK: unlock_key=32'hDEADBEEF, lock_config=0, watchdog_enable=0. Hold until wdt_config_locked=0 is sampled, then hold one more cycle and go to IDLE. On timeout after HANDSHAKE_LIMIT cycles: set handshake_fault, go to IDLE. unlock_key returns to 0 in IDLE.
- start outside IDLE and stop_req outside RUN/LOCK are ignored. If start and stop_req arrive together in IDLE, start wins.
- Sticky faults and kick_count clear only on reset or on start.

## Timing
- All outputs are registered. Reset values: every output 0, state IDLE, seen=0, counters=0.
- start sampled in cycle N → watchdog_enable=1 and timeout_value valid at N+1.
- Kick high at the cycle after the evaluation cycle. The minimum low gap between kicks is 1 cycle, guaranteed by the P clamp.
- Period counter, seen, and kick pulse all reset on entry to RUN.
- kick_period changes take effect at the next rollover. task_mask is sampled only at evaluation.
- Asynchronous reset mid-kick or mid-handshake drops all outputs to 0 immediately.

## Test plan
- Arm without lock: start with cfg_timeout=1000, cfg_lock=0 → enable=1 and timeout_value=1000 one cycle later; RUN after 2 cycles; lock_config never asserts.
- All tasks healthy: NUM_TASKS=4, mask=4'b1111, kick_period=50, each task pulses once per period → kick high 4 cycles every 50 cycles; kick_count=3 after 3 periods; starve_fault=0.
- Starvation: task 2 silent for one period, mask=4'b1111 → no kick that period, missing_tasks=4'b0100, starve_fault=1. The next healthy period kicks again.
- Heartbeat on the evaluation cycle: task 3 pulses only at counter=P-1 → kick issued.
- Lock then stop: cfg_lock=1, a responder raises wdt_config_locked after 3 cycles → RUN. stop_req → unlock_key=DEADBEEF, enable=0; locked drops → IDLE one cycle later. No acknowledge within 8 cycles → handshake_fault=1.
- Timeout and clamp: kick_period=2 → effective period 5. Pulse wdt_timeout mid-kick → kick drops next cycle, timeout_seen=1, period restarts at 0.

Source files
------------

// File: rtl/watchdog_kick_controller.sv
// Watchdog supervisor: programs, arms and optionally locks the watchdog, then kicks it only
// when every required task has checked in during a service period. Also runs the unlock path.
module watchdog_kick_controller #(
    parameter int unsigned NUM_TASKS         = 4,
    parameter int unsigned COUNTER_WIDTH     = 32,
    parameter int unsigned KICK_PULSE_CYCLES = 4,
    parameter int unsigned HANDSHAKE_LIMIT   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop_req,
    input  logic [COUNTER_WIDTH-1:0] cfg_timeout,
    input  logic                     cfg_lock,
    input  logic [COUNTER_WIDTH-1:0] kick_period,
    input  logic [NUM_TASKS-1:0]     task_mask,
    input  logic [NUM_TASKS-1:0]     heartbeat,
    input  logic                     wdt_config_locked,
    input  logic                     wdt_timeout,
    output logic                     watchdog_enable,
    output logic [COUNTER_WIDTH-1:0] timeout_value,
    output logic                     lock_config,
    output logic [31:0]              unlock_key,
    output logic                     kick_watchdog,
    output logic [NUM_TASKS-1:0]     missing_tasks,
    output logic [15:0]              kick_count,
    output logic                     starve_fault,
    output logic                     handshake_fault,
    output logic                     timeout_seen,
    output logic                     active
);

    localparam int unsigned StepW = $clog2(HANDSHAKE_LIMIT + 1);
    localparam logic [StepW-1:0] StepLast = StepW'(HANDSHAKE_LIMIT - 1);
    localparam logic [3:0] KickLast = 4'(KICK_PULSE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] MinPeriod = COUNTER_WIDTH'(KICK_PULSE_CYCLES + 1);
    localparam logic [31:0] UnlockKey = 32'hDEADBEEF;

    typedef enum logic [2:0] {StIdle, StConfig, StLock, StRun, StUnlock} state_e;

    state_e                   state_q, state_d;
    logic [StepW-1:0]         step_q, step_d;
    logic                     unl_done_q, unl_done_d;
    logic                     lock_flag_q, lock_flag_d;
    logic [COUNTER_WIDTH-1:0] tmo_q, tmo_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_TASKS-1:0]     seen_q, seen_d;
    logic                     kick_q, kick_d;
    logic [3:0]               kick_left_q, kick_left_d;
    logic [15:0]              kcount_q, kcount_d;
    logic [NUM_TASKS-1:0]     missing_q, missing_d;
    logic                     starve_q, starve_d;
    logic                     hs_fault_q, hs_fault_d;
    logic                     to_seen_q, to_seen_d;
    logic                     enable_q, lock_q, active_q;
    logic [31:0]              key_q;

    logic [COUNTER_WIDTH-1:0] period_eff;
    logic [NUM_TASKS-1:0]     eval_v;

    // The clamp guarantees at least one low cycle between consecutive kick pulses.
    assign period_eff = (kick_period < MinPeriod) ? MinPeriod : kick_period;
    assign eval_v     = seen_q | heartbeat;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q + 1'b1;
        unl_done_d  = unl_done_q;
        lock_flag_d = lock_flag_q;
        tmo_d       = tmo_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        kick_d      = kick_q;
        kick_left_d = kick_left_q;
        kcount_d    = kcount_q;
        missing_d   = missing_q;
        starve_d    = starve_q;
        hs_fault_d  = hs_fault_q;
        to_seen_d   = to_seen_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StConfig;
                    tmo_d       = cfg_timeout;
                    lock_flag_d = cfg_lock;
                    kcount_d    = '0;
                    missing_d   = '0;
                    starve_d    = 1'b0;
                    hs_fault_d  = 1'b0;
                    to_seen_d   = 1'b0;
                end
            end
            StConfig: begin
                if (step_q == StepW'(1)) state_d = lock_flag_q ? StLock : StRun;
            end
            StLock: begin
                if (stop_req) begin
                    state_d = StUnlock;
                end else if (wdt_config_locked) begin
                    state_d = StRun;
                end else if (step_q == StepLast) begin
                    hs_fault_d = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (kick_q) begin
                    if (kick_left_q == '0) kick_d = 1'b0;
                    else kick_left_d = kick_left_q - 1'b1;
                end
                if (wdt_timeout) begin
                    to_seen_d   = 1'b1;
                    cnt_d       = '0;
                    seen_d      = '0;
                    period_d    = period_eff;
                    kick_d      = 1'b0;
                    kick_left_d = '0;
                end else if (cnt_q == period_q - 1'b1) begin
                    cnt_d    = '0;
                    seen_d   = '0;
                    period_d = period_eff;
                    if ((eval_v & task_mask) == task_mask) begin
                        kick_d      = 1'b1;
                        kick_left_d = KickLast;
                        if (kcount_q != 16'hFFFF) kcount_d = kcount_q + 1'b1;
                    end else begin
                        missing_d = task_mask & ~eval_v;
                        starve_d  = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    seen_d = eval_v;
                end
                if (stop_req) state_d = StUnlock;
            end
            StUnlock: begin
                if (unl_done_q) begin
                    state_d = StIdle;
                end else if (!wdt_config_locked) begin
                    unl_done_d = 1'b1;
                end else if (step_q == StepLast) begin
                    hs_fault_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            step_d     = '0;
            unl_done_d = 1'b0;
        end
        if (state_d == StRun && state_q != StRun) begin
            cnt_d       = '0;
            seen_d      = '0;
            kick_d      = 1'b0;
            kick_left_d = '0;
            period_d    = period_eff;
        end
        if (state_d != StRun) kick_d = 1'b0;
        if (state_d == StIdle) tmo_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= '0;
            unl_done_q  <= 1'b0;
            lock_flag_q <= 1'b0;
            tmo_q       <= '0;
            period_q    <= '0;
            cnt_q       <= '0;
            seen_q      <= '0;
            kick_q      <= 1'b0;
            kick_left_q <= '0;
            kcount_q    <= '0;
            missing_q   <= '0;
            starve_q    <= 1'b0;
            hs_fault_q  <= 1'b0;
            to_seen_q   <= 1'b0;
            enable_q    <= 1'b0;
            lock_q      <= 1'b0;
            active_q    <= 1'b0;
            key_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            unl_done_q  <= unl_done_d;
            lock_flag_q <= lock_flag_d;
            tmo_q       <= tmo_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            kick_q      <= kick_d;
            kick_left_q <= kick_left_d;
            kcount_q    <= kcount_d;
            missing_q   <= missing_d;
            starve_q    <= starve_d;
            hs_fault_q  <= hs_fault_d;
            to_seen_q   <= to_seen_d;
            enable_q    <= (state_d == StConfig) || (state_d == StLock) || (state_d == StRun);
            lock_q      <= (state_d == StLock);
            active_q    <= (state_d != StIdle);
            key_q       <= (state_d == StUnlock) ? UnlockKey : 32'h0;
        end
    end

    assign watchdog_enable = enable_q;
    assign timeout_value   = tmo_q;
    assign lock_config     = lock_q;
    assign unlock_key      = key_q;
    assign kick_watchdog   = kick_q;
    assign missing_tasks   = missing_q;
    assign kick_count      = kcount_q;
    assign starve_fault    = starve_q;
    assign handshake_fault = hs_fault_q;
    assign timeout_seen    = to_seen_q;
    assign active          = active_q;

endmodule

// File: tb/tb_watchdog_kick_controller.sv
// Bench for watchdog_kick_controller: directed scenarios plus randomized heartbeat plans
// checked against a period-level model of kick/starve behaviour.
module tb_watchdog_kick_controller;

    localparam int NT = 4;
    localparam int CW = 32;
    localparam int K  = 4;
    localparam int HL = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop_req = 1'b0;
    logic [CW-1:0] cfg_timeout = '0;
    logic          cfg_lock = 1'b0;
    logic [CW-1:0] kick_period = '0;
    logic [NT-1:0] task_mask = '0;
    logic [NT-1:0] heartbeat = '0;
    logic          wdt_config_locked = 1'b0;
    logic          wdt_timeout = 1'b0;
    logic          watchdog_enable;
    logic [CW-1:0] timeout_value;
    logic          lock_config;
    logic [31:0]   unlock_key;
    logic          kick_watchdog;
    logic [NT-1:0] missing_tasks;
    logic [15:0]   kick_count;
    logic          starve_fault;
    logic          handshake_fault;
    logic          timeout_seen;
    logic          active;

    watchdog_kick_controller #(
        .NUM_TASKS(NT), .COUNTER_WIDTH(CW), .KICK_PULSE_CYCLES(K), .HANDSHAKE_LIMIT(HL)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop_req(stop_req),
        .cfg_timeout(cfg_timeout), .cfg_lock(cfg_lock), .kick_period(kick_period),
        .task_mask(task_mask), .heartbeat(heartbeat), .wdt_config_locked(wdt_config_locked),
        .wdt_timeout(wdt_timeout), .watchdog_enable(watchdog_enable),
        .timeout_value(timeout_value), .lock_config(lock_config), .unlock_key(unlock_key),
        .kick_watchdog(kick_watchdog), .missing_tasks(missing_tasks), .kick_count(kick_count),
        .starve_fault(starve_fault), .handshake_fault(handshake_fault),
        .timeout_seen(timeout_seen), .active(active)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [NT-1:0] plan[$];
    logic          obs_kick[$];
    int            model_p;
    logic [NT-1:0] model_mask;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop_req = 1'b0; heartbeat = '0; wdt_timeout = 1'b0;
        wdt_config_locked = 1'b0; cfg_lock = 1'b0; cfg_timeout = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic arm(input logic [CW-1:0] tmo, input logic lk);
        cfg_timeout = tmo; cfg_lock = lk; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Leaves the bench in the first RUN cycle (period counter at 0).
    task automatic arm_run(input int kp, input logic [NT-1:0] mask);
        kick_period = CW'(kp); task_mask = mask;
        arm(CW'($urandom), 1'b0);
        tick(); tick();
    endtask

    function automatic int eff_p(input int kp);
        return (kp < K + 1) ? K + 1 : kp;
    endfunction

    function automatic logic [NT-1:0] period_union(input int k);
        logic [NT-1:0] u = '0;
        for (int i = 0; i < model_p; i++) u = u | plan[k * model_p + i];
        return u;
    endfunction

    function automatic bit period_pass(input int k);
        return (model_mask & ~period_union(k)) == '0;
    endfunction

    // A passing period k kicks during the first K cycles of period k+1.
    function automatic logic exp_kick(input int c);
        int k = c / model_p - 1;
        int off = c % model_p;
        if (k < 0 || off >= K) return 1'b0;
        return period_pass(k);
    endfunction

    task automatic build_plan(input int n, input int pct);
        logic [NT-1:0] v;
        int idx;
        plan.delete();
        for (int c = 0; c < n * model_p; c++) plan.push_back('0);
        for (int p = 0; p < n; p++)
            for (int t = 0; t < NT; t++)
                if ($urandom_range(0, 99) < pct) begin
                    idx = p * model_p + $urandom_range(0, model_p - 1);
                    v = plan[idx]; v[t] = 1'b1; plan[idx] = v;
                end
    endtask

    task automatic drive_plan();
        obs_kick.delete();
        for (int c = 0; c < plan.size(); c++) begin
            heartbeat = plan[c];
            obs_kick.push_back(kick_watchdog);
            tick();
        end
        heartbeat = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({watchdog_enable, lock_config, kick_watchdog, active} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0000",
                {watchdog_enable, lock_config, kick_watchdog, active});
        end
        checks++;
        if (timeout_value !== '0 || unlock_key !== '0) begin
            errors++; $display("FAIL reset_values: got %0h/%0h required 0/0",
                timeout_value, unlock_key);
        end
        checks++;
        if ({kick_count, missing_tasks, starve_fault, handshake_fault, timeout_seen} !== '0) begin
            errors++; $display("FAIL reset_status: got %0h/%0h/%b%b%b required all 0",
                kick_count, missing_tasks, starve_fault, handshake_fault, timeout_seen);
        end
    endtask

    task automatic test_arm_no_lock();
        logic saw_lock = 1'b0;
        do_reset();
        kick_period = 50; task_mask = '0;
        arm(1000, 1'b0);
        checks++;
        if (watchdog_enable !== 1'b1 || active !== 1'b1) begin
            errors++; $display("FAIL arm_enable: got en=%b act=%b required 1/1",
                watchdog_enable, active);
        end
        checks++;
        if (timeout_value !== 1000) begin
            errors++; $display("FAIL arm_timeout_value: got %0d required 1000", timeout_value);
        end
        for (int i = 0; i < 12; i++) begin
            saw_lock = saw_lock | lock_config;
            tick();
        end
        checks++;
        if (saw_lock !== 1'b0 || watchdog_enable !== 1'b1) begin
            errors++; $display("FAIL arm_no_lock: got lock=%b en=%b required 0/1",
                saw_lock, watchdog_enable);
        end
    endtask

    task automatic test_healthy();
        int highs = 0;
        do_reset();
        model_p = 50; model_mask = 4'hF;
        arm_run(50, 4'hF);
        build_plan(3, 100);
        drive_plan();
        foreach (obs_kick[i]) highs += int'(obs_kick[i]);
        checks++;
        if (obs_kick[49] !== 1'b0 || obs_kick[50] !== 1'b1 || obs_kick[53] !== 1'b1 ||
            obs_kick[54] !== 1'b0 || obs_kick[103] !== 1'b1 || obs_kick[104] !== 1'b0) begin
            errors++; $display("FAIL healthy_shape: got %b%b%b%b%b%b required 011010",
                obs_kick[49], obs_kick[50], obs_kick[53], obs_kick[54], obs_kick[103],
                obs_kick[104]);
        end
        checks++;
        if (highs != 8) begin
            errors++; $display("FAIL healthy_high_cycles: got %0d required 8", highs);
        end
        checks++;
        if (kick_count !== 16'd3 || starve_fault !== 1'b0 || kick_watchdog !== 1'b1) begin
            errors++; $display("FAIL healthy_status: got cnt=%0d starve=%b kick=%b required 3/0/1",
                kick_count, starve_fault, kick_watchdog);
        end
    endtask

    task automatic test_starve();
        int highs = 0;
        do_reset();
        model_p = 20; model_mask = 4'hF;
        arm_run(20, 4'hF);
        plan.delete();
        for (int c = 0; c < 40; c++) plan.push_back('0);
        plan[3] = 4'b0001; plan[7] = 4'b1010;
        plan[22] = 4'b0101; plan[30] = 4'b1010;
        drive_plan();
        foreach (obs_kick[i]) highs += int'(obs_kick[i]);
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL starve_no_kick: got %0d high cycles required 0", highs);
        end
        checks++;
        if (missing_tasks !== 4'b0100 || starve_fault !== 1'b1) begin
            errors++; $display("FAIL starve_missing: got %b starve=%b required 0100/1",
                missing_tasks, starve_fault);
        end
        checks++;
        if (kick_watchdog !== 1'b1 || kick_count !== 16'd1) begin
            errors++; $display("FAIL starve_recover: got kick=%b cnt=%0d required 1/1",
                kick_watchdog, kick_count);
        end
    endtask

    task automatic test_eval_cycle_hb();
        do_reset();
        model_p = 10; model_mask = 4'hF;
        arm_run(10, 4'hF);
        plan.delete();
        for (int c = 0; c < 10; c++) plan.push_back('0);
        plan[0] = 4'b0111; plan[9] = 4'b1000;
        drive_plan();
        checks++;
        if (kick_watchdog !== 1'b1 || kick_count !== 16'd1 || starve_fault !== 1'b0) begin
            errors++; $display("FAIL eval_cycle_hb: got kick=%b cnt=%0d starve=%b required 1/1/0",
                kick_watchdog, kick_count, starve_fault);
        end
    endtask

    task automatic test_random();
        int n, kp, exp_cnt;
        logic [NT-1:0] exp_miss;
        logic exp_starve;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            kp = $urandom_range(0, 14);
            model_p = eff_p(kp);
            model_mask = NT'($urandom);
            if (it == 0) model_mask = '0;
            arm_run(kp, model_mask);
            n = $urandom_range(3, 6);
            build_plan(n, 85);
            drive_plan();
            for (int c = 0; c < obs_kick.size(); c++) begin
                checks++;
                if (obs_kick[c] !== exp_kick(c)) begin
                    errors++; $display("FAIL rand_kick it%0d c%0d: got %b required %b",
                        it, c, obs_kick[c], exp_kick(c));
                end
            end
            exp_cnt = 0; exp_miss = '0; exp_starve = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (period_pass(k)) exp_cnt++;
                else begin
                    exp_miss = model_mask & ~period_union(k);
                    exp_starve = 1'b1;
                end
            end
            checks++;
            if (kick_count !== 16'(exp_cnt) || missing_tasks !== exp_miss ||
                starve_fault !== exp_starve || kick_watchdog !== exp_kick(n * model_p)) begin
                errors++;
                $display("FAIL rand_status it%0d: got %0d/%b/%b/%b required %0d/%b/%b/%b", it,
                    kick_count, missing_tasks, starve_fault, kick_watchdog, exp_cnt, exp_miss,
                    exp_starve, exp_kick(n * model_p));
            end
        end
    endtask

    task automatic test_lock_stop();
        logic lock_ok = 1'b1;
        do_reset();
        kick_period = 20; task_mask = '0;
        arm(500, 1'b1);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            lock_ok = lock_ok & lock_config & watchdog_enable;
            tick();
        end
        checks++;
        if (lock_ok !== 1'b1) begin
            errors++; $display("FAIL lock_request: got %b required 1", lock_ok);
        end
        wdt_config_locked = 1'b1;
        tick();
        checks++;
        if (lock_config !== 1'b0 || handshake_fault !== 1'b0 || watchdog_enable !== 1'b1) begin
            errors++; $display("FAIL lock_ack: got lock=%b hf=%b en=%b required 0/0/1",
                lock_config, handshake_fault, watchdog_enable);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        checks++;
        if (unlock_key !== 32'hDEADBEEF || watchdog_enable !== 1'b0 || lock_config !== 1'b0) begin
            errors++; $display("FAIL unlock_outputs: got key=%h en=%b lock=%b required deadbeef/0/0",
                unlock_key, watchdog_enable, lock_config);
        end
        tick();
        wdt_config_locked = 1'b0;
        tick();
        checks++;
        if (active !== 1'b1) begin
            errors++; $display("FAIL unlock_hold: got active=%b required 1", active);
        end
        tick();
        checks++;
        if (active !== 1'b0 || unlock_key !== 32'h0 || handshake_fault !== 1'b0) begin
            errors++; $display("FAIL unlock_idle: got act=%b key=%h hf=%b required 0/0/0",
                active, unlock_key, handshake_fault);
        end
    endtask

    task automatic test_handshake_timeout();
        int n = 0;
        do_reset();
        kick_period = 20; task_mask = '0;
        arm(500, 1'b1);
        tick(); tick();
        while (lock_config && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != HL || handshake_fault !== 1'b1 || watchdog_enable !== 1'b1) begin
            errors++; $display("FAIL lock_timeout: got %0d cycles hf=%b en=%b required 8/1/1",
                n, handshake_fault, watchdog_enable);
        end
        wdt_config_locked = 1'b1;
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        n = 0;
        while (active && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != HL || handshake_fault !== 1'b1) begin
            errors++; $display("FAIL unlock_timeout: got %0d cycles hf=%b required 8/1",
                n, handshake_fault);
        end
        wdt_config_locked = 1'b0;
        arm(7, 1'b0);
        checks++;
        if (handshake_fault !== 1'b0 || timeout_value !== 7) begin
            errors++; $display("FAIL start_clears: got hf=%b tv=%0d required 0/7",
                handshake_fault, timeout_value);
        end
    endtask

    task automatic test_timeout_clamp();
        logic exp;
        do_reset();
        arm_run(2, '0);
        for (int c = 0; c < 12; c++) begin
            exp = (c >= 5) && ((c % 5) < K);
            checks++;
            if (kick_watchdog !== exp) begin
                errors++; $display("FAIL clamp_kick c%0d: got %b required %b",
                    c, kick_watchdog, exp);
            end
            if (c == 11) wdt_timeout = 1'b1;
            tick();
            wdt_timeout = 1'b0;
        end
        checks++;
        if (kick_watchdog !== 1'b0 || timeout_seen !== 1'b1 || kick_count !== 16'd2) begin
            errors++; $display("FAIL timeout_abort: got kick=%b ts=%b cnt=%0d required 0/1/2",
                kick_watchdog, timeout_seen, kick_count);
        end
        for (int c = 12; c < 17; c++) begin
            checks++;
            if (kick_watchdog !== 1'b0) begin
                errors++; $display("FAIL timeout_restart c%0d: got %b required 0", c, kick_watchdog);
            end
            tick();
        end
        checks++;
        if (kick_watchdog !== 1'b1 || kick_count !== 16'd3) begin
            errors++; $display("FAIL timeout_next_kick: got kick=%b cnt=%0d required 1/3",
                kick_watchdog, kick_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (kick_count !== 16'd3 || timeout_seen !== 1'b1 || kick_watchdog !== 1'b1) begin
            errors++; $display("FAIL start_ignored: got cnt=%0d ts=%b kick=%b required 3/1/1",
                kick_count, timeout_seen, kick_watchdog);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({kick_watchdog, watchdog_enable, active, timeout_seen} !== 4'b0 || kick_count !== '0)
        begin
            errors++; $display("FAIL async_reset: got %b cnt=%0d required 0000/0",
                {kick_watchdog, watchdog_enable, active, timeout_seen}, kick_count);
        end
    endtask

    task automatic test_idle_pulses();
        do_reset();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL stop_in_idle: got active=%b required 0", active);
        end
        cfg_timeout = 33; start = 1'b1; stop_req = 1'b1;
        tick();
        start = 1'b0; stop_req = 1'b0;
        checks++;
        if (active !== 1'b1 || watchdog_enable !== 1'b1 || timeout_value !== 33) begin
            errors++; $display("FAIL start_wins: got act=%b en=%b tv=%0d required 1/1/33",
                active, watchdog_enable, timeout_value);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arm_no_lock();
        test_healthy();
        test_starve();
        test_eval_cycle_hb();
        test_random();
        test_lock_stop();
        test_handshake_timeout();
        test_timeout_clamp();
        test_idle_pulses();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
